// File: rtl/coeff_norm_pkg.sv
// coeff_norm_pkg: shared constants, state encoding and coefficient type for the coefficient normalizer
package coeff_norm_pkg;
  localparam int DEF_WORD_LEN = 16;
  localparam int DEF_COEF_BITS = 17;
  localparam int SLOT_BITS = 2 * DEF_WORD_LEN;
  localparam int CARRY_BITS = 2;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [DEF_COEF_BITS-1:0] coef_t;
endpackage

// File: rtl/coeff_normalizer_carry_slice.sv
// carry_slice: ripples a carry through WORDS coefficients, emitting one WORD_LEN digit per coefficient
//   coefs     in  WORDS packed COEF_BITS coefficients, lowest first
//   carry_in  in  carry entering coefficient 0
//   digits    out WORDS packed WORD_LEN digits, lowest first
//   carry_out out carry leaving the top coefficient
module carry_slice
  import coeff_norm_pkg::*;
#(
  parameter int WORD_LEN  = DEF_WORD_LEN,
  parameter int COEF_BITS = DEF_COEF_BITS,
  parameter int WORDS     = 6
) (
  input  logic [WORDS*COEF_BITS-1:0] coefs,
  input  logic [CARRY_BITS-1:0]      carry_in,
  output logic [WORDS*WORD_LEN-1:0]  digits,
  output logic [CARRY_BITS-1:0]      carry_out
);
  logic [COEF_BITS:0]    s;
  logic [CARRY_BITS-1:0] c;
  always_comb begin
    c = carry_in;
    s = '0;
    digits = '0;
    for (int k = 0; k < WORDS; k++) begin
      s = {1'b0, coefs[k*COEF_BITS +: COEF_BITS]} + (COEF_BITS+1)'(c);
      digits[k*WORD_LEN +: WORD_LEN] = s[WORD_LEN-1:0];
      c = CARRY_BITS'(s >> WORD_LEN);
    end
    carry_out = c;
  end
endmodule

// File: rtl/coeff_normalizer.sv
// coeff_normalizer: sequentially carry-propagates the redundant squarer coefficient bus into a plain integer
//   clk, reset_n        clock, synchronous active-low reset
//   in_valid/in_ready   coefficient bus handshake, sq_in holds one coefficient per 2*WORD_LEN slot
//   out_valid/out_ready result handshake, out_data little-endian digits, out_carry top carry
//   busy                high outside IDLE
//   coef_err            slot high bits were set (only with COEF_CHECK_EN defined, else tied low)
module coeff_normalizer
  import coeff_norm_pkg::*;
#(
  parameter int MOD_LEN            = 1024,
  parameter int WORD_LEN           = DEF_WORD_LEN,
  parameter int REDUNDANT_ELEMENTS = 2,
  parameter int NUM_ELEMENTS       = MOD_LEN / WORD_LEN + REDUNDANT_ELEMENTS,
  parameter int COEF_BITS          = DEF_COEF_BITS,
  parameter int WORDS_PER_CYCLE    = 6,
  parameter int SQ_IN_BITS         = NUM_ELEMENTS * WORD_LEN * 2,
  parameter int OUT_BITS           = NUM_ELEMENTS * WORD_LEN
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SQ_IN_BITS-1:0] sq_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_BITS-1:0]   out_data,
  output logic [1:0]            out_carry,
  output logic                  busy,
  output logic                  coef_err
);
  localparam int SLOT     = 2 * WORD_LEN;
  localparam int BEATS    = NUM_ELEMENTS / WORDS_PER_CYCLE;
  localparam int BW       = $clog2(BEATS + 1);
  localparam int CAP_BITS = NUM_ELEMENTS * COEF_BITS;
  localparam int BEAT_IN  = WORDS_PER_CYCLE * COEF_BITS;
  localparam int BEAT_OUT = WORDS_PER_CYCLE * WORD_LEN;
  if (NUM_ELEMENTS % WORDS_PER_CYCLE != 0) begin : g_bad_fold
    $fatal(1, "NUM_ELEMENTS must be a multiple of WORDS_PER_CYCLE");
  end
  state_t                state;
  logic [CAP_BITS-1:0]   shreg;
  logic [CAP_BITS-1:0]   cap;
  logic [CARRY_BITS-1:0] carry;
  logic [CARRY_BITS-1:0] c_out;
  logic [BEAT_OUT-1:0]   digits;
  logic [BW-1:0]         beat;
  logic                  hi_err;
  always_comb begin
    cap = '0;
    for (int j = 0; j < NUM_ELEMENTS; j++) cap[j*COEF_BITS +: COEF_BITS] = sq_in[j*SLOT +: COEF_BITS];
  end
`ifdef COEF_CHECK_EN
  always_comb begin
    hi_err = 1'b0;
    for (int j = 0; j < NUM_ELEMENTS; j++) hi_err = hi_err | (|sq_in[j*SLOT+COEF_BITS +: SLOT-COEF_BITS]);
  end
`else
  assign hi_err = 1'b0;
`endif
  carry_slice #(.WORD_LEN(WORD_LEN), .COEF_BITS(COEF_BITS), .WORDS(WORDS_PER_CYCLE)) u_slice (
    .coefs    (shreg[BEAT_IN-1:0]),
    .carry_in (carry),
    .digits   (digits),
    .carry_out(c_out)
  );
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_data  <= '0;
      out_carry <= '0;
      coef_err  <= 1'b0;
      beat      <= '0;
      carry     <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          shreg    <= cap;
          carry    <= '0;
          beat     <= '0;
          coef_err <= hi_err;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          // digits enter at the top so the first beat ends at bit 0 after the last beat
          shreg    <= shreg >> BEAT_IN;
          out_data <= OUT_BITS'({digits, out_data} >> BEAT_OUT);
          carry    <= c_out;
          beat     <= beat + 1'b1;
          if (beat == BW'(BEATS - 1)) begin
            out_carry <= c_out;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        default: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          coef_err  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_coeff_normalizer.sv
// tb_coeff_normalizer: randomized and directed checks of coeff_normalizer against an arithmetic sum model
module tb_coeff_normalizer;
  localparam int WL    = 16;
  localparam int NE    = 66;
  localparam int SQW   = NE * WL * 2;
  localparam int OB    = NE * WL;
  localparam int HALF  = OB / 2;
  localparam int BEATS = 11;
  localparam int LAT   = BEATS + 1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [SQW-1:0] sq_in = '0;
  logic in_ready, out_valid, busy, coef_err;
  logic [OB-1:0] out_data;
  logic [1:0] out_carry;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  coeff_normalizer dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .sq_in(sq_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_carry(out_carry),
    .busy(busy), .coef_err(coef_err)
  );
  task automatic check(input string tag, input logic [HALF-1:0] got, input logic [HALF-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // the integer is simply sum_j c_j * 2^(16j), using only the 17 significant bits of each slot
  function automatic logic [OB+1:0] model(input logic [SQW-1:0] sq);
    logic [OB+1:0] t;
    t = '0;
    for (int j = 0; j < NE; j++) t = t + ((OB+2)'(sq[j*32 +: 17]) << (WL * j));
    return t;
  endfunction
  function automatic logic err_model(input logic [SQW-1:0] sq);
    logic e;
    e = 1'b0;
`ifdef COEF_CHECK_EN
    for (int j = 0; j < NE; j++) e = e | (sq[j*32+17 +: 15] != 15'd0);
`endif
    return e;
  endfunction
  function automatic logic [SQW-1:0] fill(input logic [31:0] v);
    logic [SQW-1:0] sq;
    for (int j = 0; j < NE; j++) sq[j*32 +: 32] = v;
    return sq;
  endfunction
  function automatic logic [SQW-1:0] rand_sq(input bit hi);
    logic [SQW-1:0] sq;
    logic [31:0] v;
    for (int j = 0; j < NE; j++) begin
      v = $urandom;
      if ($urandom_range(3) == 0) v[16:0] = '1;
      sq[j*32 +: 32] = hi ? v : {15'd0, v[16:0]};
    end
    return sq;
  endfunction
  task automatic convert(input logic [SQW-1:0] sq, input int stall);
    logic [OB+1:0] t;
    logic [OB-1:0] held;
    logic ok;
    int n;
    t = model(sq);
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    sq_in = sq;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sq_in = ~sq;
    n = 1;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", HALF'(n), HALF'(LAT));
    check("in_ready_done", in_ready, 1'b0);
    check("busy_done", busy, 1'b1);
    check("data_lo", out_data[HALF-1:0], t[HALF-1:0]);
    check("data_hi", out_data[OB-1:HALF], t[OB-1:HALF]);
    check("carry", out_carry, t[OB +: 2]);
    check("coef_err", coef_err, err_model(sq));
    held = out_data;
    ok = 1'b1;
    repeat (stall) begin
      @(posedge clk); #1;
      ok = ok & out_valid & !in_ready & (out_data == held);
    end
    if (stall > 0) check("hold", ok, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", out_valid, 1'b0);
    check("release_ready", in_ready, 1'b1);
    check("err_clear", coef_err, 1'b0);
  endtask
  initial begin
    logic [SQW-1:0] sq;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", out_data[HALF-1:0] | out_data[OB-1:HALF], '0);
    check("rst_carry", out_carry, 2'd0);
    check("rst_err", coef_err, 1'b0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    convert(fill(32'h0000_FFFF), 0);
    check("ones_lo", out_data[HALF-1:0], '1);
    sq = '0;
    sq[31:0] = 32'h0001_FFFF;
    convert(sq, 0);
    check("single_d0", out_data[15:0], 16'hFFFF);
    check("single_d1", out_data[31:16], 16'h0001);
    convert(fill(32'h0001_FFFF), 0);
    check("max_carry", out_carry, 2'd2);
    convert(rand_sq(1'b0), 20);
    sq_in = rand_sq(1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    reset_n = 1'b1;
    convert(rand_sq(1'b0), 0);
    sq = '0;
    sq[3*32 +: 32] = 32'h0002_0005;
    convert(sq, 0);
    check("slot3_digit", out_data[63:48], 16'h0005);
    for (int i = 0; i < 10; i++) convert(rand_sq(i[0]), i % 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/coeff_normalizer.md
Name: coeff_normalizer

Overview:
- Consumes the redundant squarer coefficient bus (NUM_ELEMENTS slots of 2*WORD_LEN bits, COEF_BITS significant) and carry-propagates it back into a plain nonredundant integer.
- Sits downstream of the modular squaring wrapper on the main clk domain, feeding host readback.
- Sequential: processes WORDS_PER_CYCLE coefficients per beat with a registered carry, so no full-width adder chain exists.

Parameters:
- MOD_LEN, 1024, modulus width in bits.
- WORD_LEN, 16, nonredundant digit width.
- REDUNDANT_ELEMENTS, 2, extra coefficients above MOD_LEN.
- NUM_ELEMENTS, MOD_LEN/WORD_LEN + REDUNDANT_ELEMENTS, coefficient count (66).
- COEF_BITS, 17, significant bits per coefficient slot.
- WORDS_PER_CYCLE, 6, coefficients folded per beat. NUM_ELEMENTS % WORDS_PER_CYCLE must be 0, otherwise elaboration $fatal.
- SQ_IN_BITS, NUM_ELEMENTS*WORD_LEN*2, input bus width.
- OUT_BITS, NUM_ELEMENTS*WORD_LEN, normalized output width.

Ports:
- clk  in  1  single clock for the block.
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- in_valid  in  1  coefficient bus valid.
- in_ready  out  1  block can accept a bus.
- sq_in  in  SQ_IN_BITS  coefficient j at [j*2*WORD_LEN +: 2*WORD_LEN], zero-extended.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- out_data  out  OUT_BITS  normalized integer, little-endian WORD_LEN digits.
- out_carry  out  2  carry out of the top digit.
- busy  out  1  high whenever state is not IDLE.
- coef_err  out  1  see Optional Feature.

Behaviour:
- Interface decision: single clock clk; reset_n is synchronous and active-low.
- Reset (reset_n=0 at a posedge): state=IDLE, in_ready=1, out_valid=0, out_data=0, out_carry=0, busy=0, coef_err=0, beat counter=0, carry register=0.
- A reset asserted mid-operation aborts the conversion. Captured data is discarded and no out_valid is produced.

States:
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture sq_in into an internal shift register (bits above COEF_BITS per slot are dropped), clear carry and beat counter, and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, take the WORDS_PER_CYCLE lowest remaining coefficients. For k = 0..WORDS_PER_CYCLE-1: s_k = coef_k + c_k, digit_k = s_k[WORD_LEN-1:0], c_{k+1} = s_k >> WORD_LEN, with c_0 = the carry register.
  - Every sum is at most COEF_BITS+1 bits. Every carry is at most 2 bits (coef < 2^17 and c <= 2 give c' <= 2).
  - Shift the digits into out_data from the top, so after the final beat digit 0 sits at bit 0.
  - Store c_WORDS_PER_CYCLE in the carry register and increment the beat counter.
  - When the counter reaches BEATS-1 (BEATS = NUM_ELEMENTS/WORDS_PER_CYCLE, 11 by default), load out_carry with the final carry and go to DONE.
- DONE:
  - out_valid=1, with out_data and out_carry stable.
  - On out_ready, go to IDLE. out_valid drops on the next cycle and in_ready rises on that same cycle.

Timing and handshake:
- Latency from the accept edge to out_valid = BEATS+1 cycles (12 by default).
- No back-to-back overlap: one conversion in flight at a time.
- in_valid while busy is ignored; the producer must hold it until in_ready.
- out_ready while out_valid=0 has no effect.
- Throughput: one result per BEATS+2 cycles when out_ready is held high.

Optional Feature:
- Macro COEF_CHECK_EN.
- When defined: during capture, OR-reduce slot bits [2*WORD_LEN-1:COEF_BITS] across all slots. If any bit is set, coef_err is set alongside the result; it is valid with out_valid and cleared on the DONE->IDLE transition and on reset.
- When undefined: coef_err is tied to 0 and the high slot bits are silently ignored.
- Datapath results are identical in both builds.

Decomposition:
- Package coeff_norm_pkg holds:
  - the WORD_LEN and COEF_BITS defaults;
  - the slot width constant (2*WORD_LEN);
  - the CARRY_BITS=2 constant;
  - the state enum typedef {IDLE, RUN, DONE};
  - the coefficient typedef logic [COEF_BITS-1:0].
- Sub-module carry_slice: combinational. Takes WORDS_PER_CYCLE coefficients plus a carry-in and returns the digits and the carry-out. It is instantiated once; the parent owns all registers and the FSM.

Test Plan:
- All coefficients 0xFFFF, carry-free. Accept -> out_valid exactly 12 cycles later, out_data = all-ones across OUT_BITS, out_carry=0.
- Coefficient 0 = 0x1FFFF, rest 0 -> out_data digit0=0xFFFF, digit1=0x0001, all others 0, out_carry=0.
- All coefficients 0x1FFFF, the maximum -> ripple carry crosses every beat boundary; out_data and out_carry match the reference model sum over j of c_j*2^(16j), with out_carry=2.
- Backpressure: out_ready low for 20 cycles -> out_valid and out_data hold steady and in_ready stays 0. Then pulse out_ready -> in_ready=1 on the next cycle.
- reset_n driven low at beat 5 of RUN -> next cycle busy=0, in_ready=1, out_valid=0. A new conversion then completes correctly with no stale carry.
- With COEF_CHECK_EN, slot 3 = 0x0002_0005 -> coef_err=1 with out_valid and digit3 = 0x0005. Without the macro -> coef_err=0 and the same digits.
